// File: rtl/traffic_light_monitor_if.sv
// Observation bus between a traffic-light controller and traffic_light_monitor.
// The controller side (master) drives the four lamp buses and the clr pulse;
// the monitor (slave) returns the decoded status. There is no handshake: the
// lamp buses are sampled on every rising clk edge and the status outputs are
// plain registered values, valid from the edge that updates them.
interface traffic_light_monitor_if;
  logic [2:0] light_L_R;
  logic [2:0] light_D_R;
  logic [2:0] light_L_D;
  logic [2:0] light_R_L_D;
  logic       clr;
  logic [2:0] phase;
  logic [3:0] dwell;
  logic [7:0] cycle_cnt;
  logic       tracking;
  logic       err_pat;
  logic       err_seq;
  logic       err_time;
  logic [1:0] dbg_state;

  modport master (
    output light_L_R, light_D_R, light_L_D, light_R_L_D, clr,
    input  phase, dwell, cycle_cnt, tracking, err_pat, err_seq, err_time, dbg_state
  );

  modport slave (
    input  light_L_R, light_D_R, light_L_D, light_R_L_D, clr,
    output phase, dwell, cycle_cnt, tracking, err_pat, err_seq, err_time, dbg_state
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive monitor for a six-phase traffic-light controller. Lamp buses are
// registered once, decoded on the following edge into phase/dwell, and checked
// for illegal patterns, illegal phase order and (optionally) dwell timing.
// Optional feature: define TLM_TIMING_CHECK_EN to enable dwell timing checks;
// without it err_time is tied low and no dwell comparators are built.
// dbg_state exposes the FSM: 0 = SYNC, 1 = TRACK, 2 = FAULT.
module traffic_light_monitor (
  input logic                    clk,
  input logic                    rst,
  traffic_light_monitor_if.slave bus
);

  typedef enum logic [1:0] {SYNC = 2'd0, TRACK = 2'd1, FAULT = 2'd2} state_t;

  localparam logic [2:0] PH_S1  = 3'd0;
  localparam logic [2:0] PH_S6  = 3'd5;
  localparam logic [2:0] PH_ILL = 3'd7;

  state_t     state_q, state_d;
  logic [2:0] lr_q, rld_q, ld_q, dr_q;
  logic       in_vld_q;
  logic [2:0] phase_q, phase_d, ph_smp, ph_succ;
  logic [3:0] dwell_q, dwell_d, dwell_inc;
  logic [7:0] cyc_q, cyc_d;
  logic       err_pat_q, err_pat_d, err_seq_q, err_seq_d;
  logic       new_pat, new_seq, new_time;

  // Lamp pattern order is {L_R, R_L_D, L_D, D_R}.
  function automatic logic [2:0] decode(input logic [11:0] v);
    case (v)
      12'b001_001_100_100: decode = 3'd0;
      12'b001_010_100_100: decode = 3'd1;
      12'b001_100_001_100: decode = 3'd2;
      12'b010_100_010_100: decode = 3'd3;
      12'b100_100_100_001: decode = 3'd4;
      12'b100_100_100_010: decode = 3'd5;
      default:             decode = PH_ILL;
    endcase
  endfunction

  // Decode the registered sample and derive the dwell/successor helpers.
  always_comb begin
    ph_smp    = decode({lr_q, rld_q, ld_q, dr_q});
    ph_succ   = (phase_q == PH_S6) ? PH_S1 : phase_q + 3'd1;
    dwell_inc = (dwell_q == 4'd15) ? 4'd15 : dwell_q + 4'd1;
  end

`ifdef TLM_TIMING_CHECK_EN
  logic       partial_q;
  logic       err_time_q;
  logic [3:0] exp_dw;

  function automatic logic [3:0] exp_dwell(input logic [2:0] ph);
    case (ph)
      3'd0:    exp_dwell = 4'd8;
      3'd1:    exp_dwell = 4'd3;
      3'd2:    exp_dwell = 4'd7;
      3'd3:    exp_dwell = 4'd3;
      3'd4:    exp_dwell = 4'd4;
      default: exp_dwell = 4'd3;
    endcase
  endfunction

  // Timing error: staying past the expected dwell, or leaving a full phase
  // with the wrong dwell (the S1 joined mid-way may only be too long).
  always_comb begin
    exp_dw   = exp_dwell(phase_q);
    new_time = 1'b0;
    if (in_vld_q && state_q == TRACK) begin
      if (ph_smp == phase_q) new_time = (dwell_q >= exp_dw);
      else if (partial_q)    new_time = (dwell_q > exp_dw);
      else                   new_time = (dwell_q != exp_dw);
    end
  end

  // Partial flag marks the S1 that SYNC joined; any phase change clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      partial_q  <= 1'b0;
      err_time_q <= 1'b0;
    end else begin
      err_time_q <= (err_time_q & ~bus.clr) | new_time;
      if (in_vld_q) begin
        if (state_q == SYNC && ph_smp == PH_S1) partial_q <= 1'b1;
        else if (ph_smp != phase_q)             partial_q <= 1'b0;
      end
    end
  end

  assign bus.err_time = err_time_q;
`else
  assign new_time     = 1'b0;
  assign bus.err_time = 1'b0;
`endif

  // Next-state and status update; FAULT only follows phase/dwell until clr.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dwell_d = dwell_q;
    cyc_d   = cyc_q;
    new_pat = 1'b0;
    new_seq = 1'b0;
    if (in_vld_q) begin
      phase_d = ph_smp;
      dwell_d = (ph_smp == phase_q) ? dwell_inc : 4'd1;
      case (state_q)
        SYNC: begin
          if (ph_smp == PH_ILL) begin
            new_pat = 1'b1;
            state_d = FAULT;
          end else if (ph_smp == PH_S1) begin
            state_d = TRACK;
            dwell_d = 4'd1;
          end
        end
        TRACK: begin
          if (ph_smp != phase_q) begin
            if (ph_smp == PH_ILL)                    new_pat = 1'b1;
            else if (ph_smp != ph_succ)              new_seq = 1'b1;
            else if (phase_q == PH_S6 && !new_time)  cyc_d = cyc_q + 8'd1;
          end
          if (new_pat || new_seq || new_time) state_d = FAULT;
        end
        default: ;
      endcase
    end
    if (state_q == FAULT && bus.clr) state_d = SYNC;
    err_pat_d = (err_pat_q & ~bus.clr) | new_pat;
    err_seq_d = (err_seq_q & ~bus.clr) | new_seq;
  end

  // Input sample registers and monitor state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lr_q      <= 3'd0;
      rld_q     <= 3'd0;
      ld_q      <= 3'd0;
      dr_q      <= 3'd0;
      in_vld_q  <= 1'b0;
      state_q   <= SYNC;
      phase_q   <= PH_ILL;
      dwell_q   <= 4'd0;
      cyc_q     <= 8'd0;
      err_pat_q <= 1'b0;
      err_seq_q <= 1'b0;
    end else begin
      lr_q      <= bus.light_L_R;
      rld_q     <= bus.light_R_L_D;
      ld_q      <= bus.light_L_D;
      dr_q      <= bus.light_D_R;
      in_vld_q  <= 1'b1;
      state_q   <= state_d;
      phase_q   <= phase_d;
      dwell_q   <= dwell_d;
      cyc_q     <= cyc_d;
      err_pat_q <= err_pat_d;
      err_seq_q <= err_seq_d;
    end
  end

  assign bus.phase     = phase_q;
  assign bus.dwell     = dwell_q;
  assign bus.cycle_cnt = cyc_q;
  assign bus.tracking  = (state_q == TRACK);
  assign bus.err_pat   = err_pat_q;
  assign bus.err_seq   = err_seq_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: decode table, directed multi-cycle
// sequences and a randomized controller with injected faults, all compared
// every edge against a behavioural model of the monitor rules.
module tb_traffic_light_monitor;

`ifdef TLM_TIMING_CHECK_EN
  localparam bit TIMING_EN = 1'b1;
`else
  localparam bit TIMING_EN = 1'b0;
`endif

  typedef logic [18:0] stat_t;  // {phase, dwell, cycle_cnt, tracking, pat, seq, time}
  localparam stat_t RST_STAT = {3'd7, 4'd0, 8'd0, 4'd0};

  typedef struct {
    logic [11:0] pat;
    logic [2:0]  exp_phase;
    logic        exp_trk;
    logic        exp_pat;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traffic_light_monitor_if tif();
  traffic_light_monitor dut (.clk(clk), .rst(rst), .bus(tif));

  // ---------------- reference data ----------------
  int          exp_tab[6] = '{8, 3, 7, 3, 4, 3};
  logic [11:0] pat_tab[6] = '{12'b001_001_100_100, 12'b001_010_100_100,
                              12'b001_100_001_100, 12'b010_100_010_100,
                              12'b100_100_100_001, 12'b100_100_100_010};

  logic [18:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  int m_mode;      // 0 sync, 1 track, 2 fault
  int m_phase, m_dwell, m_cyc, m_in;
  bit m_vld, m_partial, m_pat, m_seq, m_time;

  function automatic int decode_pat(input logic [11:0] v);
    for (int i = 0; i < 6; i++) if (v == pat_tab[i]) return i;
    return 7;
  endfunction

  function automatic stat_t model_stat();
    return {3'(m_phase), 4'(m_dwell), 8'(m_cyc), 1'(m_mode == 1), m_pat, m_seq, m_time};
  endfunction

  function automatic stat_t dut_stat();
    return {tif.phase, tif.dwell, tif.cycle_cnt, tif.tracking, tif.err_pat, tif.err_seq, tif.err_time};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_phase = 7; m_dwell = 0; m_cyc = 0; m_in = 7;
    m_vld = 0; m_partial = 0; m_pat = 0; m_seq = 0; m_time = 0;
  endtask

  // One rising edge: judge the sample taken on the previous edge, then take a new one.
  task automatic model_edge(input logic [11:0] pat, input bit c);
    bit np, ns, nt;
    int ph, old_ph, old_dw, old_mode;
    np = 0; ns = 0; nt = 0;
    old_mode = m_mode;
    if (m_vld) begin
      ph = m_in; old_ph = m_phase; old_dw = m_dwell;
      m_phase = ph;
      m_dwell = (ph == old_ph) ? ((old_dw < 15) ? old_dw + 1 : 15) : 1;
      if (old_mode == 0) begin
        if (ph == 7) begin np = 1; m_mode = 2; end
        else if (ph == 0) begin m_mode = 1; m_dwell = 1; m_partial = 1; end
      end else if (old_mode == 1) begin
        if (ph == old_ph) begin
          nt = TIMING_EN && (old_dw + 1 > exp_tab[old_ph]);
        end else begin
          nt = TIMING_EN && (m_partial ? (old_dw > exp_tab[old_ph]) : (old_dw != exp_tab[old_ph]));
          if (ph == 7) np = 1;
          else if (ph != (old_ph + 1) % 6) ns = 1;
          else if (old_ph == 5 && !nt) m_cyc = (m_cyc + 1) % 256;
          m_partial = 0;
        end
        if (np || ns || nt) m_mode = 2;
      end
    end
    if (old_mode == 2 && c) m_mode = 0;
    m_pat  = (m_pat  && !c) || np;
    m_seq  = (m_seq  && !c) || ns;
    m_time = (m_time && !c) || nt;
    m_in  = decode_pat(pat);
    m_vld = 1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_bus(input logic [11:0] pat);
    tif.light_L_R   = pat[11:9];
    tif.light_R_L_D = pat[8:6];
    tif.light_L_D   = pat[5:3];
    tif.light_D_R   = pat[2:0];
  endtask

  // Drive one cycle, let the model follow the edge, compare the scoreboard.
  task automatic cyc(input logic [11:0] pat, input bit c);
    stat_t e;
    set_bus(pat);
    tif.clr = c;
    @(posedge clk);
    model_edge(pat, c);
    exp_q.push_back(model_stat());
    #1;
    e = exp_q.pop_front();
    check("scoreboard", 32'(dut_stat()), 32'(e));
    tif.clr = 1'b0;
  endtask

  task automatic run(input int ph, input int n);
    for (int i = 0; i < n; i++) cyc(pat_tab[ph], 1'b0);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock edge.
  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    #1;
    check("reset_value", 32'(dut_stat()), 32'(RST_STAT));
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- test ----------------
  vec_t vecs[9];

  initial begin
    vecs[0] = '{pat_tab[0], 3'd0, 1'b1, 1'b0};
    vecs[1] = '{pat_tab[1], 3'd1, 1'b0, 1'b0};
    vecs[2] = '{pat_tab[2], 3'd2, 1'b0, 1'b0};
    vecs[3] = '{pat_tab[3], 3'd3, 1'b0, 1'b0};
    vecs[4] = '{pat_tab[4], 3'd4, 1'b0, 1'b0};
    vecs[5] = '{pat_tab[5], 3'd5, 1'b0, 1'b0};
    vecs[6] = '{12'b001_100_001_001, 3'd7, 1'b0, 1'b1};
    vecs[7] = '{12'b000_000_000_000, 3'd7, 1'b0, 1'b1};
    vecs[8] = '{12'b100_100_100_100, 3'd7, 1'b0, 1'b1};

    tif.clr = 1'b0;
    set_bus(pat_tab[0]);
    #2;

    // Decode table: status appears on the second edge after the bus is applied.
    for (int i = 0; i < 9; i++) begin
      set_bus(vecs[i].pat);
      do_reset();
      cyc(vecs[i].pat, 1'b0);
      check("tbl_edge1_phase", 32'(tif.phase), 32'd7);
      check("tbl_edge1_err_pat", 32'(tif.err_pat), 32'd0);
      cyc(vecs[i].pat, 1'b0);
      check("tbl_phase", 32'(tif.phase), 32'(vecs[i].exp_phase));
      check("tbl_tracking", 32'(tif.tracking), 32'(vecs[i].exp_trk));
      check("tbl_err_pat", 32'(tif.err_pat), 32'(vecs[i].exp_pat));
    end

    // Three legal controller cycles from reset.
    set_bus(pat_tab[0]);
    do_reset();
    cyc(pat_tab[0], 1'b0);
    check("legal_edge1_tracking", 32'(tif.tracking), 32'd0);
    cyc(pat_tab[0], 1'b0);
    check("legal_edge2_tracking", 32'(tif.tracking), 32'd1);
    check("legal_edge2_dwell", 32'(tif.dwell), 32'd1);
    run(0, 6);
    for (int p = 1; p < 6; p++) run(p, exp_tab[p]);
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 6; p++) run(p, exp_tab[p]);
    run(0, 2);
    check("legal_cycle_cnt", 32'(tif.cycle_cnt), 32'd3);
    check("legal_errors", 32'({tif.err_pat, tif.err_seq, tif.err_time}), 32'd0);
    check("legal_tracking", 32'(tif.tracking), 32'd1);

    // Overstay in S2 for four samples.
    run(0, 6);
    run(1, 4);
    cyc(pat_tab[2], 1'b0);
    check("s2_hold_dwell", 32'(tif.dwell), 32'd4);
`ifdef TLM_TIMING_CHECK_EN
    check("s2_hold_err_time", 32'(tif.err_time), 32'd1);
    check("s2_hold_tracking", 32'(tif.tracking), 32'd0);
    cyc(pat_tab[2], 1'b1);
    check("s2_clr_err_time", 32'(tif.err_time), 32'd0);
    check("s2_clr_tracking", 32'(tif.tracking), 32'd0);
`else
    check("s2_hold_err_time", 32'(tif.err_time), 32'd0);
    check("s2_hold_tracking", 32'(tif.tracking), 32'd1);
    run(2, 7);
    check("s2_after_err_time", 32'(tif.err_time), 32'd0);
    check("s2_after_tracking", 32'(tif.tracking), 32'd1);
`endif

    // S3 -> S5 jump with correct S3 dwell.
    set_bus(pat_tab[0]);
    do_reset();
    run(0, 8);
    run(1, 3);
    run(2, 7);
    run(4, 2);
    check("jump_err_seq", 32'(tif.err_seq), 32'd1);
    check("jump_err_time", 32'(tif.err_time), 32'd0);
    check("jump_tracking", 32'(tif.tracking), 32'd0);
    check("jump_phase", 32'(tif.phase), 32'd4);
    run(4, 2);
    run(5, 3);
    run(0, 2);
    check("fault_cycle_frozen", 32'(tif.cycle_cnt), 32'd0);
    check("fault_err_held", 32'(tif.err_seq), 32'd1);
    cyc(pat_tab[0], 1'b1);
    check("fault_clr_err_seq", 32'(tif.err_seq), 32'd0);

    // Join mid-S3, lock onto the first S1, then reset mid-S4.
    set_bus(pat_tab[2]);
    do_reset();
    run(2, 3);
    run(3, 3);
    run(4, 4);
    run(5, 3);
    cyc(pat_tab[0], 1'b0);
    check("join_before_s1", 32'(tif.tracking), 32'd0);
    cyc(pat_tab[0], 1'b0);
    check("join_first_s1_tracking", 32'(tif.tracking), 32'd1);
    check("join_first_s1_phase", 32'(tif.phase), 32'd0);
    run(0, 6);
    run(1, 3);
    run(2, 7);
    run(3, 2);
    check("join_mid_s4_errors", 32'({tif.err_pat, tif.err_seq, tif.err_time}), 32'd0);
    check("join_mid_s4_phase", 32'(tif.phase), 32'd3);
    do_reset();

    // Randomized controller with occasional faults, clr pulses and resets.
    begin
      int g_ph, g_cnt, g_len;
      g_ph = 0; g_cnt = 0; g_len = exp_tab[0];
      set_bus(pat_tab[0]);
      do_reset();
      for (int i = 0; i < 3000; i++) begin
        int r;
        logic [11:0] pat;
        bit c;
        r = $urandom_range(0, 999);
        if (r < 3) begin
          do_reset();
          continue;
        end
        pat = (r < 15) ? 12'($urandom) : pat_tab[g_ph];
        c = ($urandom_range(0, 39) == 0);
        cyc(pat, c);
        g_cnt++;
        if (g_cnt >= g_len) begin
          g_cnt = 0;
          if ($urandom_range(0, 19) == 0) g_ph = $urandom_range(0, 5);
          else g_ph = (g_ph + 1) % 6;
          g_len = exp_tab[g_ph];
          if ($urandom_range(0, 9) == 0) g_len = g_len + $urandom_range(0, 2) - 1;
          if (g_len < 1) g_len = 1;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
